// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types: cell encoding, game result, checker FSM states, winning-line table.
// Pure declarations, no latency; no flow control involved.
// Used by both the board-matrix block and the winner checker.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        VACIA    = 2'b00,
        JUG0     = 2'b01,
        JUG1     = 2'b10,
        INVALIDA = 2'b11
    } celda_t;

    typedef enum logic [1:0] {
        EN_JUEGO = 2'b00,
        GANA0    = 2'b01,
        GANA1    = 2'b10,
        EMPATE   = 2'b11
    } resultado_t;

    typedef enum logic [1:0] {
        REPOSO,
        BARRIDO,
        FIN
    } estado_ver_t;

    // Line k occupies LINEAS[k]; cells are row-major 0..8. Line 0 sits in the low bits.
    localparam logic [7:0][2:0][3:0] LINEAS = {
        4'd6, 4'd4, 4'd2,
        4'd8, 4'd4, 4'd0,
        4'd8, 4'd5, 4'd2,
        4'd7, 4'd4, 4'd1,
        4'd6, 4'd3, 4'd0,
        4'd8, 4'd7, 4'd6,
        4'd5, 4'd4, 4'd3,
        4'd2, 4'd1, 4'd0
    };

    function automatic logic tablero_lleno(input logic [8:0][1:0] m);
        logic ll;
        ll = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (m[i] == 2'b00) ll = 1'b0;
        end
        return ll;
    endfunction

endpackage

// File: rtl/linea_igual.sv
// Decides whether three cells form a winning line and for which player.
// Combinational, zero latency; no flow control.
// An invalid cell (11) never produces a win.
module linea_igual
    import tictactoe_pkg::*;
(
    input  celda_t a,
    input  celda_t b,
    input  celda_t c,
    output logic   gana,
    output celda_t jugador
);

    assign jugador = a;
    assign gana    = (a == b) && (b == c) && ((a == JUG0) || (a == JUG1));

endmodule

// File: rtl/verificador_ganador.sv
// Snapshots the board on colocado and scans the 8 lines one per clock to decide the game state.
// Latency: fin after edge k+1 for a win on line k, after edge 8 otherwise; colocado ignored while busy.
// GANADOR_BLOQUEO_EN: lock after a decided game (terminado) until rst.
module verificador_ganador
    import tictactoe_pkg::*;
#(
    parameter int NUM_LINEAS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            colocado,
    input  logic [8:0][1:0] matriz,
    output logic            ocupado,
    output logic            fin,
    output logic [1:0]      resultado,
    output logic [2:0]      linea
`ifdef GANADOR_BLOQUEO_EN
    ,
    output logic            terminado
`endif
);

    localparam logic [2:0] K_ULTIMA = 3'(NUM_LINEAS - 1);

    estado_ver_t     estado;
    logic [8:0][1:0] snap;
    logic            lleno;
    logic [2:0]      k;
    logic            bloqueado;

    celda_t c0, c1, c2;
    celda_t jugador;
    logic   gana;

    assign c0 = celda_t'(snap[LINEAS[k][0]]);
    assign c1 = celda_t'(snap[LINEAS[k][1]]);
    assign c2 = celda_t'(snap[LINEAS[k][2]]);

    linea_igual u_linea (
        .a       (c0),
        .b       (c1),
        .c       (c2),
        .gana    (gana),
        .jugador (jugador)
    );

`ifdef GANADOR_BLOQUEO_EN
    assign bloqueado = terminado;
`else
    assign bloqueado = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= REPOSO;
            snap      <= '0;
            lleno     <= 1'b0;
            k         <= '0;
            ocupado   <= 1'b0;
            fin       <= 1'b0;
            resultado <= EN_JUEGO;
            linea     <= '0;
`ifdef GANADOR_BLOQUEO_EN
            terminado <= 1'b0;
`endif
        end else begin
            fin <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (colocado && !bloqueado) begin
                        snap    <= matriz;
                        lleno   <= tablero_lleno(matriz);
                        k       <= '0;
                        ocupado <= 1'b1;
                        estado  <= BARRIDO;
                    end
                end
                BARRIDO: begin
                    if (gana) begin
                        resultado <= jugador;
                        linea     <= k;
                        ocupado   <= 1'b0;
                        fin       <= 1'b1;
                        estado    <= FIN;
`ifdef GANADOR_BLOQUEO_EN
                        terminado <= 1'b1;
`endif
                    end else if (k == K_ULTIMA) begin
                        resultado <= lleno ? EMPATE : EN_JUEGO;
                        linea     <= '0;
                        ocupado   <= 1'b0;
                        fin       <= 1'b1;
                        estado    <= FIN;
`ifdef GANADOR_BLOQUEO_EN
                        // A draw is also a decided game.
                        terminado <= lleno;
`endif
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                FIN: begin
                    estado <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/verificador_ganador.md
Name: verificador_ganador

Overview:
Reads the 9-cell board produced by the board-matrix block and decides the game state: in play, player 0 wins, player 1 wins, or draw.
- Triggered by the `colocado` pulse from the board block.
- Snapshots the board, then scans the 8 winning lines sequentially, one per clock.
- Reports a registered result, the winning line index, and a one-cycle `fin` pulse for the game-control FSM.

Parameters:
NUM_LINEAS, 8, number of winning lines scanned (fixed by the 3x3 board; not intended to be overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
colocado  input  1  one-cycle pulse: a piece was just placed; start evaluation
matriz  input  [8:0][1:0]  board, cell i row-major (0..8); 00 empty, 01 player 0, 10 player 1, 11 invalid
ocupado  output  1  high while the scan is in progress
fin  output  1  one-cycle pulse: result outputs updated this cycle
resultado  output  2  00 in play, 01 player 0 wins, 10 player 1 wins, 11 draw
linea  output  3  index of the winning line; valid only when resultado is 01/10, else 0

Behaviour:
- Reset values: clk and rst as above; all outputs 0; FSM in REPOSO; snapshot cleared.
- FSM states: REPOSO, BARRIDO, FIN.
- REPOSO: on `colocado`=1 at a rising edge:
  - capture `matriz` into the snapshot register;
  - register `lleno` = (all 9 snapshot cells != 00);
  - set index k=0; go to BARRIDO.
  - `ocupado` is 1 from the next cycle.
- BARRIDO: each edge evaluates line k of the snapshot.
  - Line order: 0:{0,1,2} 1:{3,4,5} 2:{6,7,8} 3:{0,3,6} 4:{1,4,7} 5:{2,5,8} 6:{0,4,8} 7:{2,4,6}.
  - A line wins when all three cells are equal and are either 01 or 10. Invalid value 11 never wins and is treated as empty.
  - On a win: latch resultado=cell value and linea=k; go to FIN (early exit).
  - No win and k=7: latch resultado = lleno ? 11 : 00 and linea=0; go to FIN.
  - Otherwise: k <= k+1.
- FIN: `fin`=1 and `ocupado`=0 for exactly one cycle; then go to REPOSO.
- Latency, counting the capture edge as edge 0: if line k wins, `fin` is high in the cycle after edge k+1. With no win, `fin` is high after edge 8 (9 edges total).
- resultado and linea hold their value until the next FIN or reset.
- `colocado` asserted during BARRIDO or FIN is ignored; no queueing. The board block guarantees at least 10 cycles between placements.
- Changes on `matriz` after the capture edge do not affect the current scan.
- rst is checked at every edge and has priority over all other logic. It aborts any scan: state REPOSO, all outputs 0, no `fin` pulse.
- The result is purely a function of the snapshot; no history carries over between evaluations.

Optional Feature:
Macro: GANADOR_BLOQUEO_EN
- Defined: once a non-00 resultado has been latched, the block locks.
  - Further `colocado` pulses are ignored; no scan, no `fin`.
  - resultado and linea stay frozen until rst.
  - Extra output `terminado` (1 bit, reset 0) is high while locked.
- Not defined: every `colocado` received in REPOSO re-evaluates the board; no `terminado` port.

Decomposition:
Package tictactoe_pkg:
- celda_t enum (VACIA=2'b00, JUG0=2'b01, JUG1=2'b10, INVALIDA=2'b11)
- resultado_t enum (EN_JUEGO, GANA0, GANA1, EMPATE)
- estado_ver_t enum (REPOSO, BARRIDO, FIN)
- LINEAS constant: [7:0][2:0][3:0] cell indices
- Shared with the board-matrix block.

Sub-module: linea_igual, purely combinational.
- Inputs: three cells.
- Outputs: `gana` and `jugador`.
- Instantiated once on the cells selected by k.

Test Plan:
1. Reset, then pulse colocado with all cells 00 -> fin after 9 edges; resultado=00, linea=0; ocupado high 8 cycles.
2. Cells 3,4,5 = 01, rest 00 -> fin after edge 2 (early exit at k=1); resultado=01, linea=1.
3. Cells 2,4,6 = 10, rest 00 -> fin after edge 8; resultado=10, linea=7.
4. Full board 01,10,01 / 01,10,10 / 10,01,01 -> no line wins; resultado=11, linea=0.
5. Start a scan, change matriz to a winning board at edge 3, pulse colocado at edge 4 -> original result (00); only one fin; assert rst at edge 5 of a new scan -> outputs 0, no fin.
6. With GANADOR_BLOQUEO_EN: win cells 0,1,2 = 01 -> resultado=01, terminado=1; clear board, pulse colocado -> no fin, outputs frozen; rst -> terminado=0.
